// File: rtl/cic_comp_pkg.sv
// -----------------------------------------------------------------------------
// cic_comp_pkg
// Shared constants, types and helpers for the CIC droop-compensation FIR
// (cic_comp_fir and its MAC sub-module).
//   DW/CW      : sample / coefficient widths (both signed)
//   NTAPS      : odd tap count; the filter is symmetric, so only NUNIQ taps
//                are stored and the mirrored pairs are pre-added
//   FRAC       : coefficient fraction bits (Q1.FRAC)
//   COEF       : unique taps, outer tap first, centre tap last. They sum, with
//                the mirrored pairs counted twice, to exactly 2^FRAC (DC gain 1).
//   ACCW       : accumulator width, wide enough that no partial sum overflows
//                for NTAPS <= 7
// No ports (package).
// -----------------------------------------------------------------------------
package cic_comp_pkg;

  localparam int DW    = 16;
  localparam int CW    = 16;
  localparam int NTAPS = 5;
  localparam int NUNIQ = (NTAPS + 1) / 2;
  localparam int FRAC  = 14;
  localparam int PRW   = DW + CW + 1;   // pre-add (DW+1) times coefficient (CW)
  localparam int ACCW  = DW + CW + 3;
  localparam int PW    = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int KW    = (NUNIQ > 1) ? $clog2(NUNIQ) : 1;

  typedef logic signed [DW-1:0]   sample_t;
  typedef logic signed [CW-1:0]   coef_t;
  typedef logic signed [PRW-1:0]  prod_t;
  typedef logic signed [ACCW-1:0] acc_t;
  typedef logic [PW-1:0]          ptr_t;
  typedef logic [KW-1:0]          tap_t;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  localparam coef_t COEF [0:NUNIQ-1] = '{-16'sd512, -16'sd1536, 16'sd20480};

  // Coefficient lookup with an explicit range guard, so an index value that
  // the FSM never produces still yields a defined zero.
  function automatic coef_t coef_at(input tap_t k);
    coef_t c;
    c = '0;
    for (int i = 0; i < NUNIQ; i++) begin
      if (int'(k) == i) c = COEF[i];
    end
    return c;
  endfunction

  // Modulo-NTAPS pointer arithmetic for the circular delay line.
  function automatic ptr_t ptr_sub(input ptr_t base, input int off);
    int t;
    t = int'(base) - off;
    if (t < 0) t = t + NTAPS;
    return ptr_t'(t);
  endfunction

  function automatic ptr_t ptr_add(input ptr_t base, input int off);
    int t;
    t = int'(base) + off;
    if (t >= NTAPS) t = t - NTAPS;
    return ptr_t'(t);
  endfunction

  // Clamp an accumulator-width value into the signed DW-bit output range.
  // The value fits when every bit above the output sign bit equals the sign.
  function automatic sample_t sat(input acc_t v);
    sample_t r;
    if (v[ACCW-1:DW-1] == {(ACCW-DW+1){v[ACCW-1]}}) begin
      r = v[DW-1:0];
    end else if (v[ACCW-1]) begin
      r = {1'b1, {(DW-1){1'b0}}};
    end else begin
      r = {1'b0, {(DW-1){1'b1}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_comp_if.sv
// -----------------------------------------------------------------------------
// cic_comp_if
// Sample stream between the CIC decimator side and the compensation FIR.
//   os_sel    : oversampling select (same encoding as cic_filter)
//   in_valid  : one-clk strobe, data_in valid
//   data_in   : signed decimated sample
//   data_out  : signed compensated sample, held between out_valid pulses
//   out_valid : one-clk strobe, data_out updated
//   busy      : MAC engine running; an in_valid now is dropped
//   overrun   : sticky, a sample was dropped
// master = sample source / consumer, slave = the filter.
// -----------------------------------------------------------------------------
interface cic_comp_if;
  import cic_comp_pkg::*;

  logic [2:0] os_sel;
  logic       in_valid;
  sample_t    data_in;
  sample_t    data_out;
  logic       out_valid;
  logic       busy;
  logic       overrun;

  modport master (
    output os_sel, in_valid, data_in,
    input  data_out, out_valid, busy, overrun
  );

  modport slave (
    input  os_sel, in_valid, data_in,
    output data_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/cic_comp_mac.sv
// -----------------------------------------------------------------------------
// cic_comp_mac
// One tap-pair per clock: pre-adds the two mirrored samples, multiplies by the
// shared coefficient and accumulates.
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous accumulator clear (start of a new output)
//   en           : add this cycle's product into the accumulator
//   single       : centre tap, use tap_a alone (no pre-add)
//   coef         : coefficient for this tap pair
//   tap_a, tap_b : mirrored delay-line samples
//   acc_sum      : accumulator plus this cycle's product (combinational), so
//                  the caller can capture the finished sum on the last tap
// -----------------------------------------------------------------------------
module cic_comp_mac
  import cic_comp_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    clr,
  input  logic    en,
  input  logic    single,
  input  coef_t   coef,
  input  sample_t tap_a,
  input  sample_t tap_b,
  output acc_t    acc_sum
);

  logic signed [DW:0] pre_add;
  prod_t              product;
  acc_t               acc_reg;

  always_comb begin
    if (single) begin
      pre_add = {tap_a[DW-1], tap_a};
    end else begin
      pre_add = {tap_a[DW-1], tap_a} + {tap_b[DW-1], tap_b};
    end
  end

  // Both operands are extended to the full product width before multiplying
  // so the sign is carried through explicitly.
  assign product = prod_t'(pre_add) * prod_t'(coef);
  assign acc_sum = acc_reg + acc_t'(product);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_reg <= '0;
    end else if (clr) begin
      acc_reg <= '0;
    end else if (en) begin
      acc_reg <= acc_sum;
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// -----------------------------------------------------------------------------
// cic_comp_fir
// Serial symmetric droop-compensation FIR placed after cic_filter. Each
// accepted sample is written to a circular delay line, then NUNIQ MAC cycles
// form the output, which is shifted by FRAC, saturated and strobed out.
// Latency in_valid -> out_valid is NUNIQ+1 clocks.
// When os_sel selects a rate too fast for the serial engine (os_sel < 2) the
// input is passed straight through one clock later.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : cic_comp_if.slave (os_sel, in_valid, data_in in;
//              data_out, out_valid, busy, overrun out)
// Build option:
//   CIC_COMP_ROUND_EN : round half up before the shift; otherwise truncate
//                       (floor). Timing is identical in both builds.
// -----------------------------------------------------------------------------
module cic_comp_fir
  import cic_comp_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  cic_comp_if.slave  bus
);

  state_t  state_reg, state_next;
  tap_t    k_reg, k_next;
  logic [2:0] os_sel_reg;
  sample_t delay_reg [NTAPS];
  ptr_t    wr_ptr_reg;
  ptr_t    base_reg;          // slot holding the newest sample, x[n]
  sample_t data_out_reg;
  logic    out_valid_reg;
  logic    overrun_reg;

  logic    os_change;
  logic    fir_mode;
  logic    accept;
  logic    drop;
  logic    bypass_hit;
  logic    last_tap;
  logic    mac_done;
  ptr_t    idx_a, idx_b;
  acc_t    mac_sum;
  acc_t    rounded;
  acc_t    scaled;

  // A change on os_sel is seen one cycle before os_sel_reg follows it; that
  // cycle flushes everything and ignores the strobe.
  assign os_change  = (bus.os_sel != os_sel_reg);
  assign fir_mode   = (os_sel_reg >= 3'd2);
  assign accept     = !os_change && fir_mode && (state_reg == IDLE) && bus.in_valid;
  assign drop       = !os_change && fir_mode && (state_reg == MAC)  && bus.in_valid;
  assign bypass_hit = !os_change && !fir_mode && bus.in_valid;
  assign last_tap   = (state_reg == MAC) && (k_reg == tap_t'(NUNIQ - 1));
  assign mac_done   = last_tap && !os_change;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    if (os_change) begin
      state_next = IDLE;
      k_next     = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_next = MAC;
            k_next     = '0;
          end
        end
        MAC: begin
          if (last_tap) begin
            state_next = IDLE;
            k_next     = '0;
          end else begin
            k_next = k_reg + tap_t'(1);
          end
        end
        default: begin
          state_next = IDLE;
          k_next     = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Delay line and pointers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NTAPS; i++) delay_reg[i] <= '0;
      wr_ptr_reg <= '0;
      base_reg   <= '0;
    end else if (os_change) begin
      for (int i = 0; i < NTAPS; i++) delay_reg[i] <= '0;
      wr_ptr_reg <= '0;
      base_reg   <= '0;
    end else if (accept) begin
      delay_reg[wr_ptr_reg] <= bus.data_in;
      base_reg              <= wr_ptr_reg;
      wr_ptr_reg            <= ptr_add(wr_ptr_reg, 1);
    end
  end

  // Tap k pairs x[n-k] with x[n-(NTAPS-1-k)]; modulo NTAPS the second slot is
  // simply base+1+k. At the centre both indices coincide and the MAC takes a
  // single term.
  assign idx_a = ptr_sub(base_reg, int'(k_reg));
  assign idx_b = ptr_add(base_reg, int'(k_reg) + 1);

  cic_comp_mac u_mac (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (accept || os_change),
    .en      (state_reg == MAC),
    .single  (k_reg == tap_t'(NUNIQ - 1)),
    .coef    (coef_at(k_reg)),
    .tap_a   (delay_reg[idx_a]),
    .tap_b   (delay_reg[idx_b]),
    .acc_sum (mac_sum)
  );

  // ---------------------------------------------------------------------------
  // Output scaling
  // ---------------------------------------------------------------------------
`ifdef CIC_COMP_ROUND_EN
  localparam acc_t RND_BIAS = acc_t'(1) <<< (FRAC - 1);
  assign rounded = mac_sum + RND_BIAS;
`else
  assign rounded = mac_sum;
`endif

  assign scaled = rounded >>> FRAC;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      os_sel_reg    <= '0;
      data_out_reg  <= '0;
      out_valid_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      os_sel_reg    <= bus.os_sel;
      out_valid_reg <= 1'b0;
      if (os_change) begin
        overrun_reg <= 1'b0;
      end else begin
        if (drop) overrun_reg <= 1'b1;
        if (mac_done) begin
          data_out_reg  <= sat(scaled);
          out_valid_reg <= 1'b1;
        end else if (bypass_hit) begin
          data_out_reg  <= bus.data_in;
          out_valid_reg <= 1'b1;
        end
      end
    end
  end

  assign bus.data_out  = data_out_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.overrun   = overrun_reg;
  assign bus.busy      = (state_reg == MAC);

endmodule

// File: tb/tb_cic_comp_fir.sv
// -----------------------------------------------------------------------------
// tb_cic_comp_fir
// Directed-plus-random bench for cic_comp_fir. Expected outputs come from a
// direct 5-tap convolution over the last accepted samples, scaled by 2^-14
// (floor, or round half up when CIC_COMP_ROUND_EN is defined) and clamped to
// 16 bits.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  cic_comp_if bus ();

  cic_comp_fir dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cur_os   = 0;

  // Full (unfolded) impulse response; hist[0] is the newest sample.
  localparam longint H [5] = '{-512, -1536, 20480, -1536, -512};
  longint hist [5];

  function automatic void model_clear();
    for (int i = 0; i < 5; i++) hist[i] = 0;
  endfunction

  function automatic void model_push(input int x);
    for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = x;
  endfunction

  function automatic int model_out();
    longint s;
    s = 0;
    for (int i = 0; i < 5; i++) s = s + H[i] * hist[i];
`ifdef CIC_COMP_ROUND_EN
    s = s + 8192;
`endif
    s = s >>> 14;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_os(input int v);
    bus.os_sel = 3'(v);
    tick();
    tick();
    if (v != cur_os) model_clear();
    cur_os = v;
    check("os_sel change overrun", bus.overrun, 0);
  endtask

  // One FIR-mode transaction: strobe x, wait (bounded) for out_valid.
  task automatic send_fir(input int x, input string tag, output int got_data);
    int cnt;
    logic got;
    int e;
    check({tag, " busy at strobe"}, bus.busy, 0);
    bus.in_valid = 1'b1;
    bus.data_in  = sample_t'(x);
    model_push(x);
    e   = model_out();
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 12) begin
      tick();
      bus.in_valid = 1'b0;
      cnt++;
      if (bus.out_valid) got = 1'b1;
    end
    check({tag, " latency"}, cnt, 4);
    check({tag, " data"}, bus.data_out, e);
    got_data = int'(bus.data_out);
    $display("%s: in=%0d out=%0d exp=%0d lat=%0d", tag, x, got_data, e, cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    int t1 [8];
    int x;
    int seen;
    t1 = '{-256, -768, 10240, -768, -256, 0, 0, 0};

    // ---------------- reset ----------------
    reset_n      = 1'b0;
    bus.os_sel   = 3'd2;
    bus.in_valid = 1'b0;
    bus.data_in  = '0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out", bus.data_out, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset busy", bus.busy, 0);
    check("reset overrun", bus.overrun, 0);
    reset_n = 1'b1;
    tick();
    tick();
    cur_os = 2;

    // ---------------- 1: impulse, os_sel=2 ----------------
    for (int i = 0; i < 8; i++) begin
      send_fir((i == 0) ? 8192 : 0, "t1 impulse", d);
      check("t1 table", d, t1[i]);
    end

    // ---------------- 2: DC 1000, os_sel=3 ----------------
    set_os(3);
    for (int i = 0; i < 8; i++) begin
      send_fir(1000, "t2 dc", d);
      if (i >= 4) check("t2 dc steady", d, 1000);
    end
    check("t2 overrun", bus.overrun, 0);

    // ---------------- 3: saturation at Nyquist ----------------
    for (int i = 0; i < 10; i++) begin
      x = (i % 2 == 0) ? 32767 : -32767;
      send_fir(x, "t3 sat", d);
      if (i >= 5) check("t3 sat clamp", d, (x > 0) ? 32767 : -32768);
    end

    // ---------------- random samples, random rate ----------------
    set_os(int'($urandom_range(2, 7)));
    for (int i = 0; i < 24; i++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      send_fir(x, "rand", d);
      repeat ($urandom_range(0, 3)) tick();
    end

    // ---------------- 4: overrun ----------------
    set_os(2);
    x = int'($urandom_range(0, 20000)) - 10000;
    check("t4 busy at strobe", bus.busy, 0);
    bus.in_valid = 1'b1;
    bus.data_in  = sample_t'(x);
    model_push(x);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;          // 2 clk after the accepted strobe: dropped
    bus.data_in  = sample_t'(12345);
    tick();
    bus.in_valid = 1'b0;
    check("t4 overrun set", bus.overrun, 1);
    tick();
    check("t4 out_valid", bus.out_valid, 1);
    check("t4 data accepted only", bus.data_out, model_out());
    $display("t4 overrun: in=%0d out=%0d", x, int'(bus.data_out));
    send_fir(4321, "t4 next", d);
    check("t4 overrun sticky", bus.overrun, 1);
    set_os(3);

    // ---------------- 5: bypass ----------------
    set_os(1);
    for (int i = 0; i < 4; i++) begin
      x = (i == 0) ? -123 : int'($urandom_range(0, 65535)) - 32768;
      bus.in_valid = 1'b1;
      bus.data_in  = sample_t'(x);
      tick();
      bus.in_valid = 1'b0;
      check("t5 bypass valid", bus.out_valid, 1);
      check("t5 bypass data", bus.data_out, x);
      check("t5 bypass busy", bus.busy, 0);
      $display("t5 bypass: in=%0d out=%0d", x, int'(bus.data_out));
    end
    check("t5 bypass overrun", bus.overrun, 0);

    // os_sel change mid-MAC aborts the result; strobe in change cycle dropped
    set_os(2);
    bus.in_valid = 1'b1;
    bus.data_in  = sample_t'(5000);
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.os_sel   = 3'd3;
    bus.in_valid = 1'b1;
    bus.data_in  = sample_t'(7777);
    tick();
    bus.in_valid = 1'b0;
    cur_os = 3;
    model_clear();
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("t5 abort no out_valid", seen, 0);
    check("t5 abort overrun", bus.overrun, 0);
    for (int i = 0; i < 6; i++) begin
      send_fir((i == 0) ? 8192 : 0, "t5 impulse", d);
      check("t5 impulse table", d, t1[i]);
    end

    // ---------------- 6: rounding ----------------
    set_os(2);
    for (int i = 0; i < 5; i++) begin
      send_fir((i == 0) ? 1 : 0, "t6 unit", d);
`ifdef CIC_COMP_ROUND_EN
      check("t6 unit table", d, (i == 2) ? 1 : 0);
`else
      check("t6 unit table", d, (i == 2) ? 1 : -1);
`endif
    end

    // reset pulse mid-MAC
    send_fir(20000, "t6 pre-reset", d);
    bus.in_valid = 1'b1;
    bus.data_in  = sample_t'(-20000);
    tick();
    bus.in_valid = 1'b0;
    tick();
    check("t6 busy before reset", bus.busy, 1);
    reset_n = 1'b0;
    #1;
    check("t6 reset data_out", bus.data_out, 0);
    check("t6 reset busy", bus.busy, 0);
    tick();
    check("t6 reset out_valid", bus.out_valid, 0);
    check("t6 reset overrun", bus.overrun, 0);
    check("t6 reset data_out held", bus.data_out, 0);
    reset_n = 1'b1;
    tick();
    tick();
    model_clear();
    send_fir(8192, "t6 post-reset", d);
    check("t6 post-reset table", d, -256);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
